pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry add/subtract unit; next generation of the 16-bit datapath adder.
//  Splits a WIDTH-bit operation into STAGES equal slices, one slice per cycle, with carry registered between stages.
//  Sits between register file read and ALU writeback; valid/ready on both sides so the pipeline can stall under backpressure.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; WIDTH % STAGES == 0 required (elaboration $error otherwise)
//  STAGES  4   pipeline depth = number of slices; 1 <= STAGES <= WIDTH; slice width SW = WIDTH/STAGES
// PORTS
//  Clk        in   1      system clock, all state on rising edge
//  Reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit accepts beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      0: A+B, 1: A-B (A + ~B + 1)
//  out_valid  out  1      result beat offered
//  out_ready  in   1      consumer accepts result this cycle
//  out_sum    out  WIDTH  result, modulo 2^WIDTH
//  out_cout   out  1      carry out of MSB (for subtract: 1 = no borrow)
//  out_ovf    out  1      signed two's-complement overflow
//  out_nzp    out  3      {N,Z,P} of out_sum (only with ADD_FLAGS_EN)
// BEHAVIOUR
//  - Stage k (0..STAGES-1) holds: valid_k, lower (k+1)*SW result bits, carry_k, unprocessed upper bits of A and ~B/B.
//  - Stage 0 on accept: B' = in_sub ? ~in_b : in_b; cin = in_sub; computes slice 0 from in_a/B'/cin.
//  - Stage k>0 computes slice k from registered operands and carry_{k-1}; last stage drives outputs directly from its regs.
//  - Handshake: beat transfers on valid & ready. ready_k = !valid_k | ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0.
//  - Stage k loads when ready_k; valid_k <= valid_{k-1} (stage 0: in_valid). Stalled stages hold all fields unchanged.
//  - in_ready combinationally depends on out_ready (no skid buffer); in_ready must never depend on in_valid.
//  - Latency: STAGES cycles from accepted input to out_valid with out_ready held 1. Throughput 1 beat/cycle.
//  - out_sum/out_cout/out_ovf/out_nzp stable while out_valid & !out_ready.
//  - out_ovf = (a[MSB] == B'[MSB]) & (sum[MSB] != a[MSB]), using B' (post-inversion), evaluated in last slice.
//  - Carry chain within slice is ripple (full-adder cells); no carry-lookahead.
//  - Reset: all valid bits 0, all data/carry regs 0 -> out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_nzp=0; in_ready=1 next cycle.
//  - Reset mid-operation: all in-flight beats dropped, none emitted; Reset overrides simultaneous in_valid.
//  - Simultaneous out-accept and in-accept with full pipe: all stages advance, no bubble.
//  - STAGES=1: single register stage, full-width ripple, latency 1.
// CONFIGURATION
//  ADD_FLAGS_EN defined: out_nzp registered alongside result in last stage; N=sum[MSB], Z=(sum==0), P=!N&!Z; reset 3'b000.
//  ADD_FLAGS_EN undefined: out_nzp tied to 3'b000, no flag logic or registers synthesised; port list unchanged.
// STRUCTURE
//  Package adder_pkg: stage_t struct template helpers, function nzp_f(sum), localparam NZP_N/NZP_Z/NZP_P bit indices.
//  Sub-module adder_slice #(SW): combinational SW-bit ripple slice: a, b, cin -> s, cout, c_msb_in (for ovf).
//  Top instantiates STAGES adder_slice via generate loop plus per-stage register/handshake logic.
// TESTING
//  1. WIDTH=16,STAGES=4: A=16'h00FF,B=16'h0001,add, out_ready=1 -> after 4 cycles sum=16'h0100,cout=0,ovf=0.
//  2. A=16'h7FFF,B=16'h0001,add -> sum=16'h8000,ovf=1,cout=0; nzp=3'b100 with ADD_FLAGS_EN.
//  3. A=16'h0005,B=16'h0005,sub -> sum=16'h0000,cout=1,ovf=0, nzp=3'b010; A=0,B=1,sub -> sum=16'hFFFF,cout=0.
//  4. Back-to-back 8 beats, out_ready low cycles 6-9 -> in_ready drops once pipe full, results in order, none lost/duplicated.
//  5. Reset asserted 2 cycles after 3 accepted beats -> no out_valid afterwards, all outputs 0, in_ready=1 next cycle.
//  6. Random 10k beats for (16,1),(16,4),(32,8),(8,8) with random out_ready -> match A±B model incl. cout/ovf.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
//   nzp_t        : {N,Z,P} condition-code vector
//   stage_ctl_t  : per-stage control bits (valid, carry into the next slice)
//   nzp_f()      : derives {N,Z,P} from a result's MSB and its zero test
package adder_pkg;

  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;

  typedef logic [2:0] nzp_t;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Takes the MSB and zero test rather than the sum itself so one helper serves any WIDTH.
  function automatic nzp_t nzp_f(input logic msb, input logic is_zero);
    nzp_t f;
    f        = '0;
    f[NZP_N] = msb;
    f[NZP_Z] = is_zero;
    f[NZP_P] = !msb && !is_zero;
    return f;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry slice built from full-adder cells.
// Ports:
//   a, b      : slice operands (b already inverted for subtract)
//   cin       : carry into bit 0
//   s         : slice sum
//   cout      : carry out of the slice MSB
//   c_msb_in  : carry into the slice MSB; cout ^ c_msb_in is signed overflow
module adder_slice #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  logic [SW:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < SW; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = carry[SW];
  assign c_msb_in = carry[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract unit. A WIDTH-bit operation is split into STAGES equal
// slices of SW = WIDTH/STAGES bits; stage k resolves slice k and registers the carry for k+1.
// Valid/ready handshake on both sides; a stage advances whenever it is empty or the stage
// after it advances, so a full pipe streams one beat per cycle.
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (in_ready never depends on in_valid)
//   in_a, in_b, in_sub   : operands; in_sub=1 computes in_a - in_b
//   out_valid/out_ready  : result handshake
//   out_sum, out_cout    : result mod 2^WIDTH, carry out (subtract: 1 = no borrow)
//   out_ovf              : signed two's-complement overflow
//   out_nzp              : {N,Z,P} of out_sum
// Configuration macro:
//   ADD_FLAGS_EN : when defined, out_nzp is registered in the last stage; otherwise tied to 0.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [2:0]       out_nzp
);

  import adder_pkg::*;

  localparam int unsigned SW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Stage registers. Operand regs hold the not-yet-consumed upper bits right-aligned, so every
  // slice reads its operands from bits [SW-1:0]. sum_q holds the resolved low (k+1)*SW bits.
  stage_ctl_t       ctl_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             ovf_q;

  // Per-stage inputs (from the port for stage 0, from the previous stage otherwise).
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] sum_src [STAGES];
  logic             cin_src [STAGES];
  logic             vld_src [STAGES];

  logic [SW-1:0]    s_slice    [STAGES];
  logic             cout_slice [STAGES];
  logic             cmsb_slice [STAGES];
  logic [WIDTH-1:0] sum_nxt    [STAGES];

  logic [STAGES:0]  ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_src[k]   = in_a;
      assign b_src[k]   = in_sub ? ~in_b : in_b;
      assign cin_src[k] = in_sub;
      assign sum_src[k] = '0;
      assign vld_src[k] = in_valid;
    end else begin : g_next
      assign a_src[k]   = a_q[k-1];
      assign b_src[k]   = b_q[k-1];
      assign cin_src[k] = ctl_q[k-1].carry;
      assign sum_src[k] = sum_q[k-1];
      assign vld_src[k] = ctl_q[k-1].valid;
    end

    adder_slice #(
      .SW (SW)
    ) u_slice (
      .a        (a_src[k][SW-1:0]),
      .b        (b_src[k][SW-1:0]),
      .cin      (cin_src[k]),
      .s        (s_slice[k]),
      .cout     (cout_slice[k]),
      .c_msb_in (cmsb_slice[k])
    );

    // Bits above the resolved slices are still zero in sum_src, so OR-ing places the slice.
    assign sum_nxt[k] = sum_src[k] | (WIDTH'(s_slice[k]) << (k * SW));
  end

  // Backward ready chain: a stage can load if it is empty or its contents move on this cycle.
  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      ready[STAGES-1-i] = !ctl_q[STAGES-1-i].valid | ready[STAGES-i];
    end
  end

  assign in_ready = ready[0];

  // Valid bits load on every ready; data fields only when a real beat arrives, so bubbles
  // leave the data registers (and hence the idle outputs) untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          ctl_q[k].valid <= vld_src[k];
          if (vld_src[k]) begin
            ctl_q[k].carry <= cout_slice[k];
            sum_q[k]       <= sum_nxt[k];
            a_q[k]         <= a_src[k] >> SW;
            b_q[k]         <= b_src[k] >> SW;
          end
        end
      end
      // Overflow is carry-into-MSB xor carry-out-of-MSB of the final slice.
      if (ready[STAGES-1] && vld_src[STAGES-1]) begin
        ovf_q <= cmsb_slice[STAGES-1] ^ cout_slice[STAGES-1];
      end
    end
  end

  assign out_valid = ctl_q[STAGES-1].valid;
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = ctl_q[STAGES-1].carry;
  assign out_ovf   = ovf_q;

`ifdef ADD_FLAGS_EN
  nzp_t nzp_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      nzp_q <= '0;
    end else if (ready[STAGES-1] && vld_src[STAGES-1]) begin
      nzp_q <= nzp_f(sum_nxt[STAGES-1][WIDTH-1], sum_nxt[STAGES-1] == '0);
    end
  end

  assign out_nzp = nzp_q;
`else
  assign out_nzp = 3'b000;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, backpressure, mid-operation reset
// and randomized traffic against an arithmetic reference model.
module tb_pipelined_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

`ifdef ADD_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic [2:0]   out_nzp;

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_nzp   (out_nzp)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [2:0]   nzp;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         q[$];
  int           n_acc = 0;
  int           n_out = 0;
  int           in_ready_lows = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout;
  logic         hold_ovf;
  logic [2:0]   hold_nzp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t   e;
    longint m, ua, ub, sa, sb, r;
    m  = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - m : ua;
    sb = b[W-1] ? ub - m : ub;
    if (sub) begin
      r      = ua - ub;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub;
      e.cout = (r >= m);
    end
    e.sum = W'((r + m) % m);
    r     = sub ? sa - sb : sa + sb;
    e.ovf = (r >= m / 2) || (r < -(m / 2));
    if (!FLAGS)                 e.nzp = 3'b000;
    else if (e.sum[W-1])        e.nzp = 3'b100;
    else if (e.sum == '0)       e.nzp = 3'b010;
    else                        e.nzp = 3'b001;
    return e;
  endfunction

  // One clock of traffic: inputs are already driven; sample at negedge, advance to posedge+1.
  task automatic cycle();
    exp_t e;
    @(negedge Clk);
    chk("in_ready", in_ready, (q.size() < S) || out_ready);
    if (q.size() == 0) chk("idle_out_valid", out_valid, 1'b0);
    if (hold_v) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", out_sum, hold_sum);
      chk("hold_cout", out_cout, hold_cout);
      chk("hold_ovf", out_ovf, hold_ovf);
      chk("hold_nzp", out_nzp, hold_nzp);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("sum", out_sum, e.sum);
        chk("cout", out_cout, e.cout);
        chk("ovf", out_ovf, e.ovf);
        chk("nzp", out_nzp, e.nzp);
      end
      n_out++;
      hold_v = 1'b0;
    end else if (out_valid) begin
      hold_v    = 1'b1;
      hold_sum  = out_sum;
      hold_cout = out_cout;
      hold_ovf  = out_ovf;
      hold_nzp  = out_nzp;
    end else begin
      hold_v = 1'b0;
    end
    if (in_valid && in_ready) begin
      q.push_back(model(in_a, in_b, in_sub));
      n_acc++;
    end
    if (!in_ready) in_ready_lows++;
    @(posedge Clk);
    #1;
  endtask

  // Single beat into an empty pipe with out_ready=1; checks latency and spec constants.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic [2:0] en);
    int lat;
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 4 * S + 10) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, S);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_cout"}, out_cout, ec);
    chk({tag, "_ovf"}, out_ovf, eo);
    chk({tag, "_nzp"}, out_nzp, FLAGS ? en : 3'b000);
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = W'(1) << (W - 1);
      3:       v = ~(W'(1) << (W - 1));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int base;
    int prev;
    bit acc_last;

    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Reset state
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_cout", out_cout, 1'b0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_out_nzp", out_nzp, 3'b000);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge Clk);
    #1;

    // Directed vectors
    directed("add_carry_ripple", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 3'b001);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3'b100);
    directed("sub_zero", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 3'b010);
    directed("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 3'b100);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 3'b001);

    // Back-to-back 8 beats, out_ready low for cycles 6-9
    base          = n_acc;
    in_ready_lows = 0;
    n_out         = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (n_acc - base) < 8;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_sub    = 1'($urandom);
      out_ready = !(c >= 6 && c <= 9);
      cycle();
    end
    in_valid = 1'b0;
    chk("bp_accepted", n_acc - base, 8);
    chk("bp_emitted", n_out, 8);
    chk("bp_in_ready_dropped", in_ready_lows > 0, 1'b1);
    chk("bp_drained", q.size(), 0);

    // Reset two cycles after three accepted beats; nothing may emerge afterwards
    base      = n_acc;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && (n_acc - base) < 3; c++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_sub   = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("rst_mid_accepted", n_acc - base, 3);
    Reset    = 1'b1;
    in_valid = 1'b1;
    @(posedge Clk);
    #1;
    Reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q.delete();
    hold_v = 1'b0;
    @(negedge Clk);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_sum", out_sum, '0);
    chk("rst_mid_cout", out_cout, 1'b0);
    chk("rst_mid_ovf", out_ovf, 1'b0);
    chk("rst_mid_nzp", out_nzp, 3'b000);
    @(posedge Clk);
    #1;
    n_out = 0;
    repeat (S + 3) cycle();
    chk("rst_mid_no_output", n_out, 0);
    chk("rst_mid_sum_after", out_sum, '0);

    // Randomized traffic with random backpressure; offered beats held until accepted
    base     = n_acc;
    acc_last = 1'b1;
    for (int c = 0; c < 40000 && (n_acc - base) < 3000; c++) begin
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = pick_operand();
        in_b     = pick_operand();
        in_sub   = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      prev      = n_acc;
      cycle();
      acc_last = (n_acc != prev);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && q.size() != 0; c++) cycle();
    chk("rand_accepted", n_acc - base, 3000);
    chk("rand_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
